// File: rtl/wb_trace_buffer_pkg.sv
// Shared trace entry type; field order matches the offsets in trace_defs.vh (TRACE_TSTAMP_EN adds tstamp).
package wb_trace_buffer_pkg;
`include "trace_defs.vh"

  localparam int IDX_W  = `TRACE_IDX_W;
  localparam int DATA_W = `TRACE_DATA_W;
  localparam int TS_W   = `TRACE_TS_W;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
`ifdef TRACE_TSTAMP_EN
    logic [TS_W-1:0]   tstamp;
`endif
  } entry_t;
endpackage

// File: rtl/trace_defs.vh
// Trace entry field widths and packed-entry bit offsets (tstamp occupies the low bits when TRACE_TSTAMP_EN).
`ifndef TRACE_DEFS_VH
`define TRACE_DEFS_VH
`define TRACE_IDX_W  5
`define TRACE_DATA_W 32
`define TRACE_TS_W   32
`ifdef TRACE_TSTAMP_EN
`define TRACE_TS_LSB   0
`define TRACE_DATA_LSB 32
`define TRACE_IDX_LSB  64
`define TRACE_ENTRY_W  69
`else
`define TRACE_DATA_LSB 0
`define TRACE_IDX_LSB  32
`define TRACE_ENTRY_W  37
`endif
`endif

// File: rtl/trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO with extra-bit pointers.
// Latency: push visible at pop_data one cycle later; pop_data reads 0 while empty.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module trace_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the read port is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/wb_trace_buffer.sv
// Captures writeback commits into a FWFT trace FIFO with drop accounting; TRACE_TSTAMP_EN adds cycle timestamps.
// Latency: commit visible on trace_* one cycle later. Backpressure: trace_ready=0 holds head; full without pop drops.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    reg_en,
  input  logic [IDX_W-1:0]        reg_idx,
  input  logic [DATA_W-1:0]       reg_data,
  input  logic                    clear,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [IDX_W-1:0]        trace_idx,
  output logic [DATA_W-1:0]       trace_data,
  output logic [TS_W-1:0]         trace_tstamp,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [DROP_W-1:0]       drop_cnt
);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  entry_t wr_entry;
  entry_t rd_entry;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop_fire;
  logic   drop;

`ifdef TRACE_TSTAMP_EN
  logic [TS_W-1:0] cycle_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    cycle_cnt <= '0;
    else if (clear) cycle_cnt <= '0;
    else            cycle_cnt <= cycle_cnt + TS_W'(1);
  end
`endif

  always_comb begin
    wr_entry      = '0;
    wr_entry.idx  = reg_idx;
    wr_entry.data = reg_data;
`ifdef TRACE_TSTAMP_EN
    wr_entry.tstamp = cycle_cnt;
`endif
  end

  assign pop_fire = !fifo_empty && trace_ready;
  // A commit is lost only when full and the consumer frees nothing this cycle.
  assign drop     = reg_en && fifo_full && !pop_fire && !clear;

  trace_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (clear),
    .push      (reg_en),
    .push_data (wr_entry),
    .pop       (pop_fire),
    .pop_data  (rd_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign trace_valid = !fifo_empty;
  assign trace_idx   = rd_entry.idx;
  assign trace_data  = rd_entry.data;
`ifdef TRACE_TSTAMP_EN
  assign trace_tstamp = rd_entry.tstamp;
`else
  assign trace_tstamp = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_ONE;
    end
  end
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Randomised bench for wb_trace_buffer against a queue-based reference model (two instances: DROP_W 16 and 2).
`timescale 1ns/1ps
module tb_wb_trace_buffer;
  localparam int DEPTH = 8;
`ifdef TRACE_TSTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        reg_en;
  logic [4:0]  reg_idx;
  logic [31:0] reg_data;
  logic        clear;
  logic        trace_ready;

  logic        trace_valid;
  logic [4:0]  trace_idx;
  logic [31:0] trace_data;
  logic [31:0] trace_tstamp;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  logic        v2;
  logic [4:0]  idx2;
  logic [31:0] data2;
  logic [31:0] ts2;
  logic [3:0]  count2;
  logic        ovf2;
  logic [1:0]  drop2;

  wb_trace_buffer #(.DEPTH(DEPTH), .DROP_W(16)) dut (
    .clk(clk), .resetn(resetn), .reg_en(reg_en), .reg_idx(reg_idx), .reg_data(reg_data),
    .clear(clear), .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_idx(trace_idx),
    .trace_data(trace_data), .trace_tstamp(trace_tstamp), .count(count), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  wb_trace_buffer #(.DEPTH(DEPTH), .DROP_W(2)) dut2 (
    .clk(clk), .resetn(resetn), .reg_en(reg_en), .reg_idx(reg_idx), .reg_data(reg_data),
    .clear(clear), .trace_valid(v2), .trace_ready(trace_ready), .trace_idx(idx2),
    .trace_data(data2), .trace_tstamp(ts2), .count(count2), .overflow(ovf2),
    .drop_cnt(drop2)
  );

  always #5 clk = ~clk;

  logic [90:0] obs_vec;
  logic [74:0] obs2_core;
  assign obs_vec   = {trace_valid, trace_idx, trace_data, trace_tstamp, count, overflow, drop_cnt};
  assign obs2_core = {v2, idx2, data2, ts2, count2, ovf2};

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic [31:0] ts;
  } ent_t;

  ent_t        q[$];
  int unsigned mcyc;
  bit          movf;
  int unsigned mdrops;
  int          checks = 0;
  int          errors = 0;

  function automatic void model_reset();
    q.delete();
    mcyc   = 0;
    movf   = 1'b0;
    mdrops = 0;
  endfunction

  function automatic logic [90:0] exp_vec();
    logic [4:0]  i;
    logic [31:0] d;
    logic [31:0] t;
    int unsigned dc;
    i = '0; d = '0; t = '0;
    if (q.size() != 0) begin
      i = q[0].idx;
      d = q[0].data;
      t = TS_ON ? q[0].ts : 32'd0;
    end
    dc = (mdrops > 65535) ? 65535 : mdrops;
    return {q.size() != 0, i, d, t, 4'(q.size()), movf, 16'(dc)};
  endfunction

  function automatic logic [1:0] exp_drop2();
    return (mdrops > 3) ? 2'd3 : 2'(mdrops);
  endfunction

  // One clock: drive at the falling edge, apply the rules at the rising edge, return at the next falling edge.
  task automatic cycle(input bit en, input logic [4:0] idx, input logic [31:0] data,
                       input bit rdy, input bit clr);
    bit   popped;
    bit   was_full;
    ent_t e;
    reg_en = en; reg_idx = idx; reg_data = data; trace_ready = rdy; clear = clr;
    @(posedge clk);
    if (!resetn || clr) begin
      model_reset();
    end else begin
      was_full = (q.size() == DEPTH);
      popped   = (q.size() != 0) && rdy;
      if (popped) void'(q.pop_front());
      if (en) begin
        if (was_full && !popped) begin
          movf = 1'b1;
          mdrops++;
        end else begin
          e.idx = idx; e.data = data; e.ts = mcyc;
          q.push_back(e);
        end
      end
      mcyc++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; reg_en = 1'b0; reg_idx = '0; reg_data = '0; clear = 1'b0; trace_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (trace_valid !== 1'b0 || count !== 4'd0) begin
      errors++; $display("FAIL reset_valid_count got valid=%b count=%0d exp 0/0", trace_valid, count);
    end
    checks++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0 || drop2 !== 2'd0) begin
      errors++; $display("FAIL reset_drop got ovf=%b drop=%0d drop2=%0d exp 0", overflow, drop_cnt, drop2);
    end
    checks++;
    if ({trace_idx, trace_data, trace_tstamp} !== 69'd0) begin
      errors++; $display("FAIL reset_outputs got idx=%h data=%h ts=%h exp 0", trace_idx, trace_data, trace_tstamp);
    end
    resetn = 1'b1;
  endtask

  task automatic test_first_commit();
    logic [31:0] ts_exp;
    ts_exp = TS_ON ? 32'd10 : 32'd0;
    repeat (10) cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    checks++;
    if (trace_valid !== 1'b0) begin
      errors++; $display("FAIL idle_valid got %b exp 0", trace_valid);
    end
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    checks++;
    if ({trace_valid, trace_idx, trace_data, count} !== {1'b1, 5'd5, 32'hDEADBEEF, 4'd1}) begin
      errors++; $display("FAIL first_commit got v=%b idx=%0d data=%h cnt=%0d exp 1/5/deadbeef/1",
                         trace_valid, trace_idx, trace_data, count);
    end
    checks++;
    if (trace_tstamp !== ts_exp) begin
      errors++; $display("FAIL first_tstamp got %0d exp %0d", trace_tstamp, ts_exp);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    checks++;
    if ({trace_valid, trace_idx, trace_data, trace_tstamp} !== 70'd0) begin
      errors++; $display("FAIL drained_zero got v=%b idx=%h data=%h ts=%h exp 0",
                         trace_valid, trace_idx, trace_data, trace_tstamp);
    end
  endtask

  task automatic test_overflow();
    logic [4:0]  fidx;
    logic [31:0] fdata;
    logic [90:0] ev;
    fidx  = 5'($urandom);
    fdata = $urandom;
    cycle(1'b1, fidx, fdata, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) cycle(1'b1, 5'($urandom), $urandom, 1'b0, 1'b0);
    checks++;
    if ({count, overflow, drop_cnt, drop2} !== {4'd8, 1'b1, 16'd2, 2'd2}) begin
      errors++; $display("FAIL overflow_state got cnt=%0d ovf=%b drop=%0d drop2=%0d exp 8/1/2/2",
                         count, overflow, drop_cnt, drop2);
    end
    checks++;
    if (trace_idx !== fidx || trace_data !== fdata) begin
      errors++; $display("FAIL overflow_head got idx=%h data=%h exp %h/%h", trace_idx, trace_data, fidx, fdata);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    ev = exp_vec();
    checks++;
    if (obs_vec !== ev || trace_data !== fdata) begin
      errors++; $display("FAIL stall_hold got %h exp %h", obs_vec, ev);
    end
  endtask

  task automatic test_full_push_pop();
    logic [4:0]  nidx;
    logic [31:0] ndata;
    logic [90:0] ev;
    nidx  = 5'($urandom);
    ndata = $urandom;
    cycle(1'b1, nidx, ndata, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd8 || drop_cnt !== 16'd2) begin
      errors++; $display("FAIL full_push_pop got cnt=%0d drop=%0d exp 8/2", count, drop_cnt);
    end
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      ev = exp_vec();
      checks++;
      if (obs_vec !== ev) begin
        errors++; $display("FAIL drain_pop%0d got %h exp %h", i, obs_vec, ev);
      end
    end
    checks++;
    if (trace_idx !== nidx || trace_data !== ndata || count !== 4'd1) begin
      errors++; $display("FAIL new_entry_head got idx=%h data=%h cnt=%0d exp %h/%h/1",
                         trace_idx, trace_data, count, nidx, ndata);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_drop_saturate();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    checks++;
    if (drop_cnt !== 16'd0 || drop2 !== 2'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL pre_sat_clear got drop=%0d drop2=%0d ovf=%b exp 0", drop_cnt, drop2, overflow);
    end
    for (int i = 0; i < 11; i++) cycle(1'b1, 5'($urandom), $urandom, 1'b0, 1'b0);
    checks++;
    if (drop2 !== 2'd3 || ovf2 !== 1'b1) begin
      errors++; $display("FAIL sat_at3 got drop2=%0d ovf2=%b exp 3/1", drop2, ovf2);
    end
    for (int i = 0; i < 2; i++) cycle(1'b1, 5'($urandom), $urandom, 1'b0, 1'b0);
    checks++;
    if (drop2 !== 2'd3 || drop_cnt !== 16'd5 || count !== 4'd8) begin
      errors++; $display("FAIL sat_hold got drop2=%0d drop=%0d cnt=%0d exp 3/5/8", drop2, drop_cnt, count);
    end
  endtask

  task automatic test_clear();
    logic [90:0] ev;
    for (int i = 0; i < 4; i++) cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL pre_clear got cnt=%0d ovf=%b exp 4/1", count, overflow);
    end
    cycle(1'b1, 5'($urandom), $urandom, 1'b1, 1'b1);
    checks++;
    if ({count, trace_valid, overflow, drop_cnt, drop2} !== {4'd0, 1'b0, 1'b0, 16'd0, 2'd0}) begin
      errors++; $display("FAIL clear_state got cnt=%0d v=%b ovf=%b drop=%0d drop2=%0d exp all 0",
                         count, trace_valid, overflow, drop_cnt, drop2);
    end
    cycle(1'b1, 5'($urandom), $urandom, 1'b0, 1'b0);
    ev = exp_vec();
    checks++;
    if (obs_vec !== ev) begin
      errors++; $display("FAIL post_clear_commit got %h exp %h", obs_vec, ev);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_random(input int n, input int en_pct, input int rdy_pct);
    logic [90:0] ev;
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(0, 99) < en_pct, 5'($urandom), $urandom,
            $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) < 2);
      ev = exp_vec();
      checks++;
      if (obs_vec !== ev) begin
        errors++; $display("FAIL rand_cycle%0d got %h exp %h", i, obs_vec, ev);
      end
      checks++;
      if (obs2_core !== ev[90:16] || drop2 !== exp_drop2()) begin
        errors++; $display("FAIL rand2_cycle%0d got %h/%0d exp %h/%0d", i, obs2_core, drop2, ev[90:16], exp_drop2());
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [90:0] ev;
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'($urandom), $urandom, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd3) begin
      errors++; $display("FAIL pre_reset_count got %0d exp 3", count);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || trace_valid !== 1'b0 || trace_tstamp !== 32'd0) begin
      errors++; $display("FAIL async_reset got cnt=%0d v=%b ts=%h exp 0/0/0", count, trace_valid, trace_tstamp);
    end
    @(negedge clk);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    resetn = 1'b1;
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd0 || trace_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL post_release got cnt=%0d v=%b ovf=%b exp 0/0/0", count, trace_valid, overflow);
    end
    cycle(1'b1, 5'($urandom), $urandom, 1'b0, 1'b0);
    ev = exp_vec();
    checks++;
    if (obs_vec !== ev) begin
      errors++; $display("FAIL post_release_commit got %h exp %h", obs_vec, ev);
    end
  endtask

  initial begin
    test_reset();
    test_first_commit();
    test_overflow();
    test_full_push_pop();
    test_drop_saturate();
    test_clear();
    test_random(300, 70, 30);
    test_random(300, 50, 80);
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got time=%0t exp completion before 200000", $time);
    $fatal(1, "watchdog");
  end
endmodule
